mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single memory port between instruction fetch (IF) and load/store (LS).
//  Decodes each 32-bit address against the text/data/stack/MMIO map and drives a region select
//  plus a region-local word index. Faults unmapped or illegal accesses and times out stalled ones.
//  Sits between the core FSM (FETCH/MEM states) and the memory/MMIO subsystems.
// PARAMETERS
//  TEXT_DEPTH  1024  text region size in bytes; text = [0x00400000, +TEXT_DEPTH)
//  DATA_DEPTH  1024  data memory bytes; half is data, half is stack (DIV = DATA_DEPTH/2)
//  MMIO_SIZE   16    MMIO region bytes; MMIO = [0xffff0000, +MMIO_SIZE)
//  IDX_W       8     mem_idx width in bits; must hold max(TEXT_DEPTH, DIV, MMIO_SIZE)/4 - 1
//  TIMEOUT     15    cycles in BUSY without mem_ack before the access is aborted
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  if_req     in   1      fetch request; hold with if_addr stable until if_gnt
//  if_addr    in   32     fetch byte address
//  if_gnt     out  1      one-cycle pulse: fetch accepted
//  if_rvalid  out  1      one-cycle pulse: fetch complete
//  if_rdata   out  32     fetch data; valid with if_rvalid
//  if_fault   out  1      qualifies if_rvalid: access faulted
//  ls_req     in   1      load/store request; hold with ls_* stable until ls_gnt
//  ls_we      in   1      1 = store
//  ls_be      in   4      byte enables
//  ls_addr    in   32     load/store byte address
//  ls_wdata   in   32     store data
//  ls_gnt     out  1      one-cycle pulse: LS accepted
//  ls_rvalid  out  1      one-cycle pulse: LS complete
//  ls_rdata   out  32     load data; 0 for stores and faults
//  ls_fault   out  1      qualifies ls_rvalid
//  mem_req    out  1      shared port request; held until mem_ack
//  mem_we     out  1      latched write flag
//  mem_be     out  4      latched byte enables; 4'hf for fetch
//  mem_sel    out  2      region: 0 text, 1 data, 2 stack, 3 MMIO
//  mem_idx    out  IDX_W  word index = (addr - region_base) >> 2
//  mem_wdata  out  32     latched store data
//  mem_ack    in   1      memory completes the access this cycle
//  mem_rdata  in   32     read data; valid with mem_ack
// BEHAVIOUR
//  - Reset (async, rst_n=0): every output 0; state IDLE; last_owner = IF; timeout counter = 0.
//    Reset mid-access drops mem_req immediately. No response is issued for the aborted access.
//  - Region bases, inclusive ranges:
//    text  [0x00400000, 0x00400000+TEXT_DEPTH-1]
//    data  [0x10010000, 0x10010000+DIV-1]
//    stack [0x7fffeffc+4-DIV, 0x7fffefff]; base = 0x7fffeffc+4-DIV
//    MMIO  [0xffff0000, 0xffff0000+MMIO_SIZE-1]
//  - Fault conditions, any of:
//    address in no region; addr[1:0] != 0; IF address outside text; LS store to text.
//  - FSM states: IDLE, BUSY, RESP.
//  - IDLE: if exactly one requester is active, select it. If both are active, select the one
//    that is not last_owner (alternation). Latch addr/we/be/wdata/sel/idx and update last_owner.
//    Next cycle: the winner's gnt = 1 for one cycle. If the access is legal, state = BUSY and
//    mem_req = 1. If it faults, state = RESP with the fault set and mem_req stays 0.
//  - BUSY: mem_* outputs stay stable. The counter increments each cycle that mem_ack = 0.
//    On mem_ack, capture mem_rdata (for a store, capture 0); drop mem_req next cycle; go to RESP.
//    If the counter reaches TIMEOUT with no ack, drop mem_req, set the fault, rdata = 0, go to RESP.
//    mem_ack outside BUSY is ignored.
//  - RESP: the owner's rvalid = 1 for one cycle, with rdata/fault; then go to IDLE. The other
//    requester's outputs stay 0. A req still high in IDLE is treated as a new request.
//  - Latency: req sampled at cycle N, gnt and mem_req at N+1. With mem_ack at cycle M, rvalid is
//    at M+1 (minimum N+2). A faulted access has rvalid at N+2.
//  - At most one access is outstanding. gnt, rvalid and fault are never asserted to both requesters.
// TESTING
//  1. IF req addr 0x00400008, mem_ack 1 cycle later, rdata 0x00500093 -> mem_sel=0, mem_idx=2,
//     mem_be=4'hf; if_gnt at N+1; if_rvalid at N+2 with if_rdata=0x00500093, if_fault=0.
//  2. LS store 0x10010004, wdata 0xdeadbeef, be 4'hf -> mem_sel=1, mem_idx=1, mem_we=1;
//     ls_rvalid with ls_rdata=0, ls_fault=0.
//  3. LS load 0x7fffeffc, DATA_DEPTH=1024 -> mem_sel=2, mem_idx=127.
//     LS load 0xffff000c -> mem_sel=3, mem_idx=3.
//  4. IF and LS held high together for 4 accesses after reset -> grants in order LS, IF, LS, IF.
//  5. LS load 0x20000000, LS store 0x00400000, IF fetch 0x10010000 -> each: gnt, then rvalid with
//     fault=1 one cycle later; mem_req never asserted.
//  6. mem_ack withheld -> mem_req deasserts after 15 BUSY cycles, rvalid with fault=1 and rdata=0.
//     Separate run: rst_n pulsed low mid-BUSY -> all outputs 0 at once, no rvalid; next request
//     is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and shared memory-port signals around mem_port_arbiter.
// slave: the arbiter's view; master: the core/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned IDX_W = 8
);
  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [31:0]      if_rdata;
  logic             if_fault;

  logic             ls_req;
  logic             ls_we;
  logic [3:0]       ls_be;
  logic [31:0]      ls_addr;
  logic [31:0]      ls_wdata;
  logic             ls_gnt;
  logic             ls_rvalid;
  logic [31:0]      ls_rdata;
  logic             ls_fault;

  logic             mem_req;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [1:0]       mem_sel;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic             mem_ack;
  logic [31:0]      mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_fault,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_fault,
    output mem_req, mem_we, mem_be, mem_sel, mem_idx, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_fault,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_fault,
    input  mem_req, mem_we, mem_be, mem_sel, mem_idx, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// Alternating arbitration, address decode to text/data/stack/MMIO, fault and timeout handling.
module mem_port_arbiter #(
  parameter int unsigned TEXT_DEPTH = 1024,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned MMIO_SIZE  = 16,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned DIV        = DATA_DEPTH / 2;
  localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
  localparam logic [31:0] STACK_BASE = 32'h7fff_f000 - 32'(DIV);
  localparam logic [31:0] MMIO_BASE  = 32'hffff_0000;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_q, last_d;
  logic             gnt_q, gnt_d;
  logic             fault_q, fault_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [1:0]       sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             pick_ls;
  logic [31:0]      addr;
  logic [31:0]      off_text, off_data, off_stack, off_mmio, off;
  logic             in_text, in_data, in_stack, in_mmio;
  logic             dec_fault;
  logic [1:0]       dec_sel;

  // Pick the arbitration winner and decode its address into region, offset and fault.
  always_comb begin
    pick_ls   = bus.ls_req && (!bus.if_req || last_q == OWN_IF);
    addr      = pick_ls ? bus.ls_addr : bus.if_addr;
    off_text  = addr - TEXT_BASE;
    off_data  = addr - DATA_BASE;
    off_stack = addr - STACK_BASE;
    off_mmio  = addr - MMIO_BASE;
    in_text   = off_text  < 32'(TEXT_DEPTH);
    in_data   = off_data  < 32'(DIV);
    in_stack  = off_stack < 32'(DIV);
    in_mmio   = off_mmio  < 32'(MMIO_SIZE);
    dec_sel   = 2'd0;
    off       = off_text;
    if (in_data) begin
      dec_sel = 2'd1;
      off     = off_data;
    end else if (in_stack) begin
      dec_sel = 2'd2;
      off     = off_stack;
    end else if (in_mmio) begin
      dec_sel = 2'd3;
      off     = off_mmio;
    end
    dec_fault = !(in_text || in_data || in_stack || in_mmio)
             || (addr[1:0] != 2'b00)
             || (!pick_ls && !in_text)
             || (pick_ls && bus.ls_we && in_text);
  end

  // Next-state and next-register logic for the IDLE/BUSY/RESP access sequence.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = 1'b0;
    fault_d = fault_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.if_req || bus.ls_req) begin
          owner_d = pick_ls ? OWN_LS : OWN_IF;
          last_d  = pick_ls ? OWN_LS : OWN_IF;
          gnt_d   = 1'b1;
          we_d    = pick_ls && bus.ls_we;
          be_d    = pick_ls ? bus.ls_be : 4'hf;
          wdata_d = pick_ls ? bus.ls_wdata : '0;
          sel_d   = dec_sel;
          idx_d   = IDX_W'(off >> 2);
          fault_d = dec_fault;
          rdata_d = '0;
          // A decode fault also passes through BUSY (mem_req held low) so the
          // grant cycle precedes the response cycle exactly as for a legal access.
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (fault_q) begin
          state_d = RESP;
        end else if (bus.mem_ack) begin
          rdata_d = we_q ? '0 : bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            fault_d = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched access registers; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;
      gnt_q   <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  logic resp;
  assign resp = (state_q == RESP);

  assign bus.if_gnt    = gnt_q && (owner_q == OWN_IF);
  assign bus.if_rvalid = resp && (owner_q == OWN_IF);
  assign bus.if_rdata  = bus.if_rvalid ? rdata_q : '0;
  assign bus.if_fault  = bus.if_rvalid && fault_q;

  assign bus.ls_gnt    = gnt_q && (owner_q == OWN_LS);
  assign bus.ls_rvalid = resp && (owner_q == OWN_LS);
  assign bus.ls_rdata  = bus.ls_rvalid ? rdata_q : '0;
  assign bus.ls_fault  = bus.ls_rvalid && fault_q;

  assign bus.mem_req   = (state_q == BUSY) && !fault_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_idx   = idx_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random and directed requests, a reference decode model,
// and independent monitors for grants, memory-port requests and responses.
module tb_mem_port_arbiter;

  localparam int unsigned TEXT_DEPTH = 1024;
  localparam int unsigned DATA_DEPTH = 1024;
  localparam int unsigned MMIO_SIZE  = 16;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned TIMEOUT    = 15;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.IDX_W(IDX_W)) bus ();

  mem_port_arbiter #(
    .TEXT_DEPTH(TEXT_DEPTH),
    .DATA_DEPTH(DATA_DEPTH),
    .MMIO_SIZE (MMIO_SIZE),
    .IDX_W     (IDX_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        ls;
    logic [31:0] rdata;
    logic        fault;
    int          kind;   // 0 memory ack, 1 decode fault, 2 timeout
  } rsp_t;

  typedef struct {
    logic [1:0]       sel;
    logic [IDX_W-1:0] idx;
    logic             we;
    logic [3:0]       be;
    logic [31:0]      wdata;
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];
  logic gnt_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_gnt_cyc = 0;
  int          last_ack_cyc = 0;
  int          lat = 0;
  bit          stall = 0;
  bit          fast = 0;
  bit          fixed_en = 0;
  logic [31:0] fixed_val = '0;
  logic        m_last_ls = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Reference memory contents as a function of region and word index.
  function automatic logic [31:0] memf(input logic [1:0] s, input logic [IDX_W-1:0] i);
    return {s, 6'h15, 8'(i), 16'hc3a5};
  endfunction

  // Reference decode from the address map, using plain range arithmetic.
  task automatic model(input logic ls, input logic we, input logic [31:0] a,
                       output logic [1:0] sel, output logic [IDX_W-1:0] idx, output logic fault);
    longint unsigned x, base, size;
    logic hit;
    x = longint'(a);
    hit = 1'b1;
    if (x >= 64'h0040_0000 && x < 64'h0040_0000 + TEXT_DEPTH) begin
      sel = 2'd0; base = 64'h0040_0000;
    end else if (x >= 64'h1001_0000 && x < 64'h1001_0000 + DATA_DEPTH / 2) begin
      sel = 2'd1; base = 64'h1001_0000;
    end else if (x >= 64'h7fff_f000 - DATA_DEPTH / 2 && x <= 64'h7fff_efff) begin
      sel = 2'd2; base = 64'h7fff_f000 - DATA_DEPTH / 2;
    end else if (x >= 64'hffff_0000 && x < 64'hffff_0000 + MMIO_SIZE) begin
      sel = 2'd3; base = 64'hffff_0000;
    end else begin
      sel = 2'd0; base = x; hit = 1'b0;
    end
    size = (x - base) / 4;
    idx = IDX_W'(size);
    fault = !hit || (x % 4 != 0) || (!ls && sel != 2'd0) || (ls && we && hit && sel == 2'd0);
  endtask

  // Queue the expected grant, memory request and response for one access.
  task automatic push_exp(input logic ls, input logic [31:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] wd);
    logic [1:0]       sel;
    logic [IDX_W-1:0] idx;
    logic             fault;
    rsp_t r;
    mem_t m;
    model(ls, we, a, sel, idx, fault);
    gnt_q.push_back(ls);
    r.ls = ls;
    if (fault) begin
      r.fault = 1'b1; r.rdata = '0; r.kind = 1;
    end else begin
      m.sel = sel; m.idx = idx; m.we = we; m.be = be; m.wdata = wd;
      mem_q.push_back(m);
      if (stall) begin
        r.fault = 1'b1; r.rdata = '0; r.kind = 2;
      end else begin
        r.fault = 1'b0; r.kind = 0;
        r.rdata = we ? 32'h0 : (fixed_en ? fixed_val : memf(sel, idx));
      end
    end
    rsp_q.push_back(r);
  endtask

  // Issue one slot: IF only, LS only, or both together; waits for all responses.
  task automatic run_slot(input bit use_if, input bit use_ls, input logic [31:0] ia,
                          input logic [31:0] la, input logic lwe, input logic [3:0] lbe,
                          input logic [31:0] lwd);
    logic first_ls, who;
    bit   pend_if, pend_ls, first;
    int   w, n;
    first_ls = (use_if && use_ls) ? !m_last_ls : use_ls;
    n = (use_if && use_ls) ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      who = (k == 0) ? first_ls : !first_ls;
      if (who) push_exp(1'b1, la, lwe, lbe, lwd);
      else     push_exp(1'b0, ia, 1'b0, 4'hf, 32'h0);
      m_last_ls = who;
    end
    @(negedge clk);
    bus.if_req = use_if;  bus.if_addr = ia;
    bus.ls_req = use_ls;  bus.ls_addr = la;
    bus.ls_we = lwe;      bus.ls_be = lbe;  bus.ls_wdata = lwd;
    pend_if = use_if; pend_ls = use_ls; first = 1; w = 0;
    while ((pend_if || pend_ls) && w < 200) begin
      @(negedge clk);
      w++;
      if (pend_if && bus.if_gnt) begin
        bus.if_req = 1'b0; pend_if = 0;
        if (first) check("gnt_latency", 128'(w), 128'(1));
        first = 0;
      end
      if (pend_ls && bus.ls_gnt) begin
        bus.ls_req = 1'b0; pend_ls = 0;
        if (first) check("gnt_latency", 128'(w), 128'(1));
        first = 0;
      end
      if (stall && !first && !pend_if && !pend_ls) begin
        n = 0;
        while (bus.mem_req && n < 100) begin
          n++;
          @(negedge clk);
        end
        check("timeout_busy_cycles", 128'(n), 128'(TIMEOUT));
      end
    end
    if (pend_if || pend_ls) begin
      flag("gnt_wait_expired");
      summary();
    end
    w = 0;
    while (rsp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (rsp_q.size() != 0) begin
      flag("rvalid_wait_expired");
      summary();
    end
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic logic [127:0] outvec();
    return 128'({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_fault,
                 bus.ls_gnt, bus.ls_rvalid, bus.ls_rdata, bus.ls_fault,
                 bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_sel, bus.mem_idx, bus.mem_wdata});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("outputs_in_reset", outvec(), 128'h0);
    rsp_q.delete();
    m_last_ls = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] um [8];
    um = '{32'h0040_0400, 32'h1000_fffc, 32'h1001_0200, 32'h7fff_edfc,
           32'h7fff_f000, 32'hffff_0010, 32'h0000_0000, 32'h003f_fffc};
    case ($urandom_range(0, 7))
      0, 6:    return 32'h0040_0000 + 4 * $urandom_range(0, TEXT_DEPTH / 4 - 1);
      1, 7:    return 32'h1001_0000 + 4 * $urandom_range(0, DATA_DEPTH / 8 - 1);
      2:       return 32'h7fff_f000 - DATA_DEPTH / 2 + 4 * $urandom_range(0, DATA_DEPTH / 8 - 1);
      3:       return 32'hffff_0000 + 4 * $urandom_range(0, MMIO_SIZE / 4 - 1);
      4:       return 32'h1001_0000 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      default: return um[$urandom_range(0, 7)];
    endcase
  endfunction

  // Memory responder: random or zero latency, withholds ack when stalling,
  // and pulses stray acks while no request is pending.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        if (!stall) begin
          if (fast || lat == 0) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = fixed_en ? fixed_val : memf(bus.mem_sel, bus.mem_idx);
            last_ack_cyc = cyc;
            lat = $urandom_range(0, 3);
          end else begin
            lat--;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.mem_ack = 1'b1;
      end
    end
  end

  // Grant monitor.
  initial begin
    logic e;
    forever begin
      @(negedge clk);
      if (bus.if_gnt && bus.ls_gnt) flag("gnt_both");
      else if (bus.if_gnt || bus.ls_gnt) begin
        last_gnt_cyc = cyc;
        if (gnt_q.size() == 0) flag("gnt_unexpected");
        else begin
          e = gnt_q.pop_front();
          check("gnt_owner_ls", 128'(bus.ls_gnt), 128'(e));
        end
      end
    end
  end

  // Memory-port monitor: contents on each new request, stability while held.
  initial begin
    logic prev;
    mem_t e;
    logic [127:0] snap;
    prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev) begin
        if (mem_q.size() == 0) flag("mem_req_unexpected");
        else begin
          e = mem_q.pop_front();
          check("mem_sel", 128'(bus.mem_sel), 128'(e.sel));
          check("mem_idx", 128'(bus.mem_idx), 128'(e.idx));
          check("mem_we",  128'(bus.mem_we),  128'(e.we));
          check("mem_be",  128'(bus.mem_be),  128'(e.be));
          if (e.we) check("mem_wdata", 128'(bus.mem_wdata), 128'(e.wdata));
        end
        snap = 128'({bus.mem_we, bus.mem_be, bus.mem_sel, bus.mem_idx, bus.mem_wdata});
      end else if (bus.mem_req) begin
        check("mem_stable", 128'({bus.mem_we, bus.mem_be, bus.mem_sel, bus.mem_idx, bus.mem_wdata}), snap);
      end
      prev = bus.mem_req;
    end
  end

  // Response monitor.
  initial begin
    rsp_t r;
    int   exp_cyc;
    forever begin
      @(negedge clk);
      if (bus.if_rvalid && bus.ls_rvalid) flag("rvalid_both");
      else if (bus.if_rvalid || bus.ls_rvalid) begin
        if (rsp_q.size() == 0) flag("rvalid_unexpected");
        else begin
          r = rsp_q.pop_front();
          check("rvalid_owner_ls", 128'(bus.ls_rvalid), 128'(r.ls));
          check("rdata", 128'(r.ls ? bus.ls_rdata : bus.if_rdata), 128'(r.rdata));
          check("fault", 128'(r.ls ? bus.ls_fault : bus.if_fault), 128'(r.fault));
          check("other_side_zero",
                128'(r.ls ? {bus.if_rdata, bus.if_fault} : {bus.ls_rdata, bus.ls_fault}), 128'h0);
          exp_cyc = (r.kind == 0) ? last_ack_cyc + 1 :
                    (r.kind == 1) ? last_gnt_cyc + 1 : last_gnt_cyc + int'(TIMEOUT);
          check("rvalid_cycle", 128'(cyc), 128'(exp_cyc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    flag("global_time_limit");
    summary();
  end

  initial begin
    bit ui, ul;
    int kind;
    logic [31:0] ia;
    int w;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_be = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", outvec(), 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fast = 1;
    fixed_en = 1; fixed_val = 32'h0050_0093;
    run_slot(1, 0, 32'h0040_0008, 32'h0, 1'b0, 4'hf, 32'h0);
    fixed_en = 0;
    run_slot(0, 1, 32'h0, 32'h1001_0004, 1'b1, 4'hf, 32'hdead_beef);
    run_slot(0, 1, 32'h0, 32'h7fff_effc, 1'b0, 4'hf, 32'h0);
    run_slot(0, 1, 32'h0, 32'hffff_000c, 1'b0, 4'hf, 32'h0);

    do_reset();
    run_slot(1, 1, 32'h0040_0010, 32'h1001_0008, 1'b0, 4'hf, 32'h0);
    run_slot(1, 1, 32'h0040_0014, 32'h1001_000c, 1'b0, 4'hf, 32'h0);

    run_slot(0, 1, 32'h0, 32'h2000_0000, 1'b0, 4'hf, 32'h0);
    run_slot(0, 1, 32'h0, 32'h0040_0000, 1'b1, 4'h3, 32'h1234_5678);
    run_slot(1, 0, 32'h1001_0000, 32'h0, 1'b0, 4'hf, 32'h0);
    fast = 0;

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 2);
      ui = (kind != 1);
      ul = (kind != 0);
      ia = ($urandom_range(0, 9) < 6) ? 32'h0040_0000 + 4 * $urandom_range(0, TEXT_DEPTH / 4 - 1)
                                      : rand_addr();
      run_slot(ui, ul, ia, rand_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
    end

    stall = 1;
    run_slot(0, 1, 32'h0, 32'h1001_0010, 1'b0, 4'hf, 32'h0);

    @(negedge clk);
    push_exp(1'b1, 32'h1001_0020, 1'b0, 4'hf, 32'h0);
    bus.ls_req = 1'b1; bus.ls_addr = 32'h1001_0020; bus.ls_we = 1'b0; bus.ls_be = 4'hf;
    w = 0;
    while (!bus.ls_gnt && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.ls_req = 1'b0;
    if (!bus.ls_gnt) flag("reset_test_gnt_expired");
    repeat (4) @(negedge clk);
    stall = 0;
    do_reset();
    repeat (3) @(negedge clk);
    run_slot(0, 1, 32'h0, 32'hffff_0004, 1'b0, 4'hf, 32'h0);
    run_slot(1, 0, 32'h0040_0020, 32'h0, 1'b0, 4'hf, 32'h0);

    repeat (5) @(negedge clk);
    summary();
  end

endmodule
